// File: rtl/mod10_counter.sv
// Synchronous mod-N (decade by default) BCD counter with up/down, clear, load,
// cascade carry/borrow and a registered seven-segment decode of the count.
module mod10_counter #(
  parameter int unsigned MODULUS        = 10,
  parameter int unsigned WIDTH          = 4,
  parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             sclr,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             co,
  output logic [6:0]       seg
);

  localparam logic [WIDTH-1:0] MAX_Q    = WIDTH'(MODULUS - 1);
  localparam logic [6:0]       SEG_ZERO = SEG_ACTIVE_LOW ? 7'b1000000 : 7'b0111111;

  logic [WIDTH-1:0] q_q, q_d;
  logic [6:0]       seg_q, seg_d;

  // Segment pattern {g,f,e,d,c,b,a}, active high; hex A-F beyond 9.
  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    logic [6:0] p;
    case (v)
      4'h0:    p = 7'b0111111;
      4'h1:    p = 7'b0000110;
      4'h2:    p = 7'b1011011;
      4'h3:    p = 7'b1001111;
      4'h4:    p = 7'b1100110;
      4'h5:    p = 7'b1101101;
      4'h6:    p = 7'b1111101;
      4'h7:    p = 7'b0000111;
      4'h8:    p = 7'b1111111;
      4'h9:    p = 7'b1101111;
      4'hA:    p = 7'b1110111;
      4'hB:    p = 7'b1111100;
      4'hC:    p = 7'b0111001;
      4'hD:    p = 7'b1011110;
      4'hE:    p = 7'b1111001;
      default: p = 7'b1110001;
    endcase
    return p;
  endfunction

  // Next count: sclr > load > en; illegal states fall back to 0 on a counting edge.
  always_comb begin
    q_d = q_q;
    if (sclr) begin
      q_d = '0;
    end else if (load) begin
      q_d = (32'(din) < MODULUS) ? din : '0;
    end else if (en) begin
      if (32'(q_q) >= MODULUS) begin
        q_d = '0;
      end else if (up_dn) begin
        q_d = (q_q == MAX_Q) ? '0 : q_q + WIDTH'(1);
      end else begin
        q_d = (q_q == '0) ? MAX_Q : q_q - WIDTH'(1);
      end
    end
  end

  // Decoding the next state keeps seg aligned with q in the same cycle.
  always_comb begin
    seg_d = seg_decode(4'(q_d)) ^ {7{SEG_ACTIVE_LOW}};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q   <= '0;
      seg_q <= SEG_ZERO;
    end else begin
      q_q   <= q_d;
      seg_q <= seg_d;
    end
  end

  assign q   = q_q;
  assign seg = seg_q;
  assign tc  = up_dn ? (q_q == MAX_Q) : (q_q == '0);
  assign co  = tc & en;

endmodule

// File: tb/tb_mod10_counter.sv
// Directed self-checking bench for mod10_counter: decade unit, a hex/active-low
// variant sharing the same controls, and a two-digit cascade.
module tb_mod10_counter;

  logic       clk = 1'b0;
  logic       rst, en, up_dn, sclr, load;
  logic [3:0] din;

  logic [3:0] q, hex_q, tens_q;
  logic       tc, co, hex_tc, hex_co, tens_tc, tens_co;
  logic [6:0] seg, hex_seg, tens_seg;

  int checks = 0;
  int errors = 0;

  localparam logic [6:0] SEG_TAB [10] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
    7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111
  };

  always #5 clk = ~clk;

  mod10_counter dut (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .sclr(sclr), .load(load),
    .din(din), .q(q), .tc(tc), .co(co), .seg(seg)
  );

  mod10_counter #(.MODULUS(16), .WIDTH(4), .SEG_ACTIVE_LOW(1'b1)) u_hex (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .sclr(sclr), .load(load),
    .din(din), .q(hex_q), .tc(hex_tc), .co(hex_co), .seg(hex_seg)
  );

  mod10_counter u_tens (
    .clk(clk), .rst(rst), .en(co), .up_dn(1'b1), .sclr(1'b0), .load(1'b0),
    .din(4'd0), .q(tens_q), .tc(tens_tc), .co(tens_co), .seg(tens_seg)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_q;
    rst = 1'b1; en = 1'b0; up_dn = 1'b1; sclr = 1'b0; load = 1'b0; din = 4'd0;

    // Reset state
    #12;
    check("rst_q", 32'(q), 32'd0);
    check("rst_seg", 32'(seg), 32'(7'b0111111));
    check("rst_hex_seg", 32'(hex_seg), 32'(7'b1000000));
    check("rst_tc_up", 32'(tc), 32'd0);
    up_dn = 1'b0;
    #1;
    check("rst_tc_dn", 32'(tc), 32'd1);
    check("rst_co_en0", 32'(co), 32'd0);
    up_dn = 1'b1;
    rst = 1'b0;
    en = 1'b1;

    // Free-run up for 25 clocks
    for (int i = 1; i <= 25; i++) begin
      tick();
      exp_q = i % 10;
      check($sformatf("run_q%0d", i), 32'(q), 32'(exp_q));
      check($sformatf("run_tc%0d", i), 32'(tc), (exp_q == 9) ? 32'd1 : 32'd0);
      check($sformatf("run_co%0d", i), 32'(co), (exp_q == 9) ? 32'd1 : 32'd0);
      check($sformatf("run_seg%0d", i), 32'(seg), 32'(SEG_TAB[exp_q]));
    end

    // One step down to 4, then hold with en=0
    up_dn = 1'b0;
    tick();
    check("dn_to4", 32'(q), 32'd4);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_q", 32'(q), 32'd4);
      check("hold_co", 32'(co), 32'd0);
    end

    // Clear, then count down through the wrap
    sclr = 1'b1;
    tick();
    check("sclr_q", 32'(q), 32'd0);
    sclr = 1'b0;
    en = 1'b1;
    #1;
    check("dn_tc_at0", 32'(tc), 32'd1);
    check("dn_co_at0", 32'(co), 32'd1);
    tick();
    check("dn_wrap_q", 32'(q), 32'd9);
    check("dn_wrap_seg", 32'(seg), 32'(7'b1101111));
    check("dn_tc_at9", 32'(tc), 32'd0);
    check("dn_co_at9", 32'(co), 32'd0);
    tick();
    check("dn_q8", 32'(q), 32'd8);

    // q=9 counting up but disabled: tc high, co low
    en = 1'b0; up_dn = 1'b1; load = 1'b1; din = 4'd9;
    tick();
    load = 1'b0;
    #1;
    check("ld9_q", 32'(q), 32'd9);
    check("ld9_tc", 32'(tc), 32'd1);
    check("ld9_co_en0", 32'(co), 32'd0);
    en = 1'b1;
    #1;
    check("ld9_co_en1", 32'(co), 32'd1);
    tick();
    check("wrap_q", 32'(q), 32'd0);
    check("wrap_co", 32'(co), 32'd0);

    // Load and clear priority
    en = 1'b0; load = 1'b1; din = 4'd7;
    tick();
    check("ld7_q", 32'(q), 32'd7);
    check("ld7_seg", 32'(seg), 32'(7'b0000111));
    check("ld7_hex_q", 32'(hex_q), 32'd7);
    din = 4'd12;
    tick();
    check("ld12_q", 32'(q), 32'd0);
    check("ld12_seg", 32'(seg), 32'(7'b0111111));
    check("ld12_hex_q", 32'(hex_q), 32'd12);
    check("ld12_hex_seg", 32'(hex_seg), 32'(7'b1000110));
    check("ld12_hex_tc", 32'(hex_tc), 32'd0);
    check("ld12_hex_co", 32'(hex_co), 32'd0);
    din = 4'd3; en = 1'b1;
    tick();
    check("ld_over_en", 32'(q), 32'd3);
    sclr = 1'b1;
    tick();
    check("sclr_over_ld", 32'(q), 32'd0);
    sclr = 1'b0;

    // Asynchronous reset mid-count at q=6
    en = 1'b0; din = 4'd6;
    tick();
    check("ld6_q", 32'(q), 32'd6);
    load = 1'b0; en = 1'b1;
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_q", 32'(q), 32'd0);
    check("async_rst_seg", 32'(seg), 32'(7'b0111111));
    check("async_rst_hex_seg", 32'(hex_seg), 32'(7'b1000000));
    #2;
    rst = 1'b0;
    tick();
    check("rel_q", 32'(q), 32'd1);

    // Two-digit cascade: 100 clocks from reset
    rst = 1'b1;
    #2;
    rst = 1'b0;
    check("casc_rst_tens", 32'(tens_q), 32'd0);
    repeat (99) tick();
    check("casc99_units", 32'(q), 32'd9);
    check("casc99_tens", 32'(tens_q), 32'd9);
    check("casc99_tens_seg", 32'(tens_seg), 32'(7'b1101111));
    check("casc99_tens_tc", 32'(tens_tc), 32'd1);
    check("casc99_tens_co", 32'(tens_co), 32'd1);
    tick();
    check("casc100_units", 32'(q), 32'd0);
    check("casc100_tens", 32'(tens_q), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mod10_counter.md
Name: mod10_counter

Overview:
Synchronous decade (mod-10) counter with a 4-bit binary-coded-decimal (BCD) count output. It counts 0..9 and wraps on the rising edge of clk. Optional controls are up/down, enable, synchronous clear and parallel load. A cascade carry/borrow output and a registered seven-segment decode let multiple instances form multi-digit decimal counters and display drivers.

Parameters:
MODULUS, 10, count modulus; legal range 2..16; default gives decade behaviour.
WIDTH, 4, width of q and din; must satisfy 2**WIDTH >= MODULUS.
SEG_ACTIVE_LOW, 0, 1 = seg outputs inverted (common-anode display).

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
en  input  1  count enable; counting occurs only when en=1
up_dn  input  1  1 = count up, 0 = count down
sclr  input  1  synchronous clear to 0
load  input  1  synchronous parallel load of din
din  input  WIDTH  load value
q  output  WIDTH  current count, registered
tc  output  1  terminal count, combinational (q==MODULUS-1 when up_dn=1; q==0 when up_dn=0)
co  output  1  cascade carry/borrow = tc & en, combinational
seg  output  7  seven-segment pattern {g,f,e,d,c,b,a} of q, registered

Behaviour:
- Reset: rst=1 asynchronously forces q=0 and seg=pattern for 0 (7'b0111111, or its inverse when SEG_ACTIVE_LOW=1), independent of clk. While rst=1, tc and co follow q=0 (tc=1 only if up_dn=0).
- Release of rst is synchronous-safe: the first count occurs on the first rising edge of clk after rst deasserts.
- Per-edge priority: rst > sclr > load > en. Inputs not selected by priority are ignored that cycle.
- sclr=1: q<=0.
- load=1: q<=din if din<MODULUS; otherwise q<=0 (out-of-range loads clamp to 0).
- en=1, up_dn=1: q<=q+1; if q==MODULUS-1 then q<=0 (wrap).
- en=1, up_dn=0: q<=q-1; if q==0 then q<=MODULUS-1 (wrap).
- en=0 with no sclr/load: q holds.
- Illegal state (q>=MODULUS, unreachable in normal operation): next counting edge forces q<=0.
- Latency: q changes 1 clock after the controlling input is sampled. seg is registered from the next-state value, so seg always matches q in the same cycle.
- seg decode for digits 0-9 uses the standard segment patterns. For values 10-15 (MODULUS>10 only), decode hex A-F.
- co asserts for exactly the cycle preceding a wrap. For cascading, the next digit's en is driven from co.
- With en, up_dn tied high and sclr, load tied low, q sequence after reset is 0,1,...,9,0,... with period 10 clocks. tc is high for 1 of every 10 cycles.

Test Plan:
- Reset: assert rst mid-count at q=6, asynchronously between edges -> q=0 immediately, seg=7'b0111111. Release -> q=1 after the first edge.
- Free-run up: en=1, up_dn=1 for 25 clocks from reset -> q=1..9,0,1..9,0,1..5. tc and co high only when q=9.
- Down count: up_dn=0 from q=0 -> next edge q=9, then 8. co high while q=0 and en=1.
- Enable hold: en=0 for 3 clocks at q=4 -> q stays 4, co=0 even if q reaches 9 with en=0.
- Load/clear priority: load=1, din=7 -> q=7. Load din=12 -> q=0. sclr=1 together with load=1, din=3 -> q=0.
- Cascade: two instances, units co driving tens en, 100 clocks from reset -> tens=9 and units=9 at clock 99, both 0 at clock 100.
